// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan path: segment encodings and
// the anode idle pattern helper.
package seg7_pkg;

  // Segments are active-low, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // All-ones anode pattern for n digits (every digit disabled).
  function automatic logic [15:0] ANODES_OFF(input int n);
    logic [16:0] m;
    m = (17'd1 << n) - 17'd1;
    return m[15:0];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed common-anode scan controller with PWM brightness, leading-zero
// suppression and a frame-synchronous shadow register for tear-free updates.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 391,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    zero_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int DIGIT_W = $clog2(NUM_DIGITS);
  localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [NUM_DIGITS-1:0] ANODES_IDLE = NUM_DIGITS'(ANODES_OFF(NUM_DIGITS));
  localparam logic [BRIGHT_W-1:0]   PHASE_LAST  = '1;
  localparam logic [DIGIT_W-1:0]    DIGIT_LAST  = DIGIT_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST    = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]        pre_cnt;
  logic [BRIGHT_W-1:0]     phase;
  logic [DIGIT_W-1:0]      digit;
  logic                    load_pending;

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    sh_zs;
  logic [BRIGHT_W-1:0]     sh_bright;

  logic step_tick, slot_end, frame_end;

  assign step_tick = (pre_cnt == PRE_LAST);
  assign slot_end  = step_tick && (phase == PHASE_LAST);
  assign frame_end = slot_end && (digit == DIGIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      phase   <= '0;
      digit   <= '0;
    end else begin
      pre_cnt <= step_tick ? '0 : pre_cnt + 1'b1;
      if (step_tick) phase <= phase + 1'b1;
      if (slot_end)  digit <= (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
    end
  end

  // Loads collapse into one pending request; the data sampled is whatever
  // sits on the inputs at the frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_pending <= 1'b0;
      sh_value     <= '0;
      sh_dp        <= '0;
      sh_blank     <= '1;
      sh_zs        <= 1'b0;
      sh_bright    <= '0;
    end else if (frame_end && (load_pending || load)) begin
      load_pending <= 1'b0;
      sh_value     <= value;
      sh_dp        <= dp;
      sh_blank     <= blank;
      sh_zs        <= zero_suppress;
      sh_bright    <= brightness;
    end else if (load) begin
      load_pending <= 1'b1;
    end
  end

  // Priority chain from the MSB down: a digit is suppressed while every
  // nibble from the top down to it is zero. Digit 0 always shows.
  logic [NUM_DIGITS-1:0] supp;
  logic                  zero_run;

  always_comb begin
    supp     = '0;
    zero_run = sh_zs;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (sh_value[4*i +: 4] == 4'h0);
      supp[i]  = zero_run;
    end
  end

  logic [3:0]            cur_nibble;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic                  cur_dark, cur_on;

  assign cur_nibble = sh_value[{digit, 2'b00} +: 4];
  assign digit_sel  = NUM_DIGITS'(1) << digit;
  assign cur_dark   = sh_blank[digit] || supp[digit];
  // The top PWM phase can never satisfy phase < brightness, giving a dark
  // guard step before the anode moves on.
  assign cur_on     = (phase < sh_bright) && !cur_dark;

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anodes      <= ANODES_IDLE;
      seg         <= SEG_OFF;
      dp_out      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      anodes      <= cur_on ? ~digit_sel : ANODES_IDLE;
      seg         <= cur_dark ? SEG_OFF : dec_seg;
      dp_out      <= sh_blank[digit] ? 1'b1 : ~sh_dp[digit];
      frame_start <= (pre_cnt == '0) && (phase == '0) && (digit == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller: 4 digits, 8-cycle slots, 32-cycle frames.
module tb_seg7_scan_controller;

  localparam int N  = 4;
  localparam int PS = 2;
  localparam int BW = 2;

  logic          clk;
  logic          reset;
  logic [4*N-1:0] value;
  logic [N-1:0]  dp;
  logic [N-1:0]  blank;
  logic          zero_suppress;
  logic [BW-1:0] brightness;
  logic          load;
  logic [N-1:0]  anodes;
  logic [6:0]    seg;
  logic          dp_out;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  seg7_scan_controller #(
    .NUM_DIGITS (N),
    .PRESCALE   (PS),
    .BRIGHT_W   (BW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .value         (value),
    .dp            (dp),
    .blank         (blank),
    .zero_suppress (zero_suppress),
    .brightness    (brightness),
    .load          (load),
    .anodes        (anodes),
    .seg           (seg),
    .dp_out        (dp_out),
    .frame_start   (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance negedge by negedge until frame_start is seen, within a bound.
  task automatic wait_frame_start(input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("frame_start_seen", {31'd0, found}, 32'd1);
  endtask

  // Called on the frame_start sample; checks all 32 output cycles of the frame.
  // segs = {d3,d2,d1,d0} 7-bit codes, dpo = expected dp_out per digit.
  task automatic check_frame(input string tag, input int bright, input logic [3:0] on_mask,
                             input logic [27:0] segs, input logic [3:0] dpo);
    int d, ph;
    logic [3:0] one, exp_an;
    one = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      d  = k / 8;
      ph = (k % 8) / 2;
      exp_an = (on_mask[d] && (ph < bright)) ? ~(one << d) : 4'hF;
      chk($sformatf("%s_anodes_k%0d", tag, k), {28'd0, anodes}, {28'd0, exp_an});
      chk($sformatf("%s_seg_k%0d", tag, k), {25'd0, seg}, {25'd0, segs[7*d +: 7]});
      chk($sformatf("%s_dp_k%0d", tag, k), {31'd0, dp_out}, {31'd0, dpo[d]});
      chk($sformatf("%s_fs_k%0d", tag, k), {31'd0, frame_start}, {31'd0, (k == 0)});
    end
  endtask

  initial begin
    reset = 1'b1;
    value = '0;
    dp = '0;
    blank = '0;
    zero_suppress = 1'b0;
    brightness = '0;
    load = 1'b0;

    // Reset values
    step(3);
    chk("rst_anodes", {28'd0, anodes}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp_out}, 32'd1);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    reset = 1'b0;

    // Two dark frames with no load applied
    wait_frame_start(2);
    check_frame("dark0", 0, 4'b0000, {4{7'h7F}}, 4'hF);
    wait_frame_start(1);
    check_frame("dark1", 0, 4'b0000, {4{7'h7F}}, 4'hF);

    // Load 12A0 mid-frame; old (dark) shadow holds until the next frame
    wait_frame_start(1);
    step(5);
    value = 16'h12A0; dp = 4'b0000; blank = 4'b0000; zero_suppress = 1'b0; brightness = 2'd3;
    load = 1'b1;
    step(1);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("pre_update_dark", {28'd0, anodes}, 32'hF);
    end
    wait_frame_start(40);
    check_frame("v12a0", 3, 4'hF, {7'h79, 7'h24, 7'h08, 7'h40}, 4'hF);

    // Load asserted only in the frame_end cycle, with zero suppression
    wait_frame_start(1);
    step(30);
    value = 16'h0050; dp = 4'b1000; zero_suppress = 1'b1;
    load = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame_start(2);
    check_frame("zsup", 3, 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0111);

    // Brightness 1: two on-cycles per slot
    wait_frame_start(1);
    step(5);
    value = 16'h12A0; dp = 4'b0000; zero_suppress = 1'b0; brightness = 2'd1;
    load = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame_start(40);
    check_frame("bright1", 1, 4'hF, {7'h79, 7'h24, 7'h08, 7'h40}, 4'hF);

    // Brightness 0: fully dark anodes
    wait_frame_start(1);
    step(5);
    brightness = 2'd0;
    load = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame_start(40);
    check_frame("bright0", 0, 4'hF, {7'h79, 7'h24, 7'h08, 7'h40}, 4'hF);

    // Two loads, value changed between them; second pulse in frame_end cycle
    wait_frame_start(1);
    step(5);
    value = 16'h3456; brightness = 2'd3;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(4);
    value = 16'h789B;
    step(20);
    load = 1'b1;
    step(1);
    load = 1'b0;
    value = 16'hFFFF;
    wait_frame_start(2);
    check_frame("dbl_load", 3, 4'hF, {7'h78, 7'h00, 7'h10, 7'h03}, 4'hF);
    wait_frame_start(1);
    check_frame("dbl_hold", 3, 4'hF, {7'h78, 7'h00, 7'h10, 7'h03}, 4'hF);

    // Reset mid-slot of digit 2
    wait_frame_start(1);
    step(19);
    reset = 1'b1;
    step(1);
    chk("mid_rst_anodes", {28'd0, anodes}, 32'hF);
    chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
    chk("mid_rst_dp", {31'd0, dp_out}, 32'd1);
    chk("mid_rst_fs", {31'd0, frame_start}, 32'd0);
    reset = 1'b0;
    wait_frame_start(1);
    chk("post_rst_dark", {28'd0, anodes}, 32'hF);
    value = 16'h12A0; dp = 4'b0000; blank = 4'b0000; zero_suppress = 1'b0; brightness = 2'd3;
    step(30);
    load = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame_start(2);
    check_frame("post_rst", 3, 4'hF, {7'h79, 7'h24, 7'h08, 7'h40}, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
